// File: rtl/mem_rd_responder_if.sv
// Read-command / write / response bundle between the radix initiator and the memory responder.
// The initiator (master) drives commands, stall and RAM writes; the responder (slave) returns data and status.
interface mem_rd_responder_if #(
   parameter int MEM_ADDR_W = 16,
   parameter int DATA_W     = 512,
   parameter int TAG_W      = 8,
   parameter int LVL_W      = 4
);
   logic                  rsend;
   logic [MEM_ADDR_W-1:0] raddr;
   logic [TAG_W-1:0]      rtag_in;
   logic                  memc_cmd_full;
   logic                  stall;
   logic                  wvalid;
   logic [MEM_ADDR_W-1:0] waddr;
   logic [DATA_W-1:0]     wdata;
   logic                  rvalid;
   logic [DATA_W-1:0]     rdata;
   logic [TAG_W-1:0]      rtag;
   logic [LVL_W-1:0]      fifo_level;
   logic                  overflow;

   modport master (
      output rsend, raddr, rtag_in, stall, wvalid, waddr, wdata,
      input  memc_cmd_full, rvalid, rdata, rtag, fifo_level, overflow
   );

   modport slave (
      input  rsend, raddr, rtag_in, stall, wvalid, waddr, wdata,
      output memc_cmd_full, rvalid, rdata, rtag, fifo_level, overflow
   );
endinterface

// File: rtl/mem_rd_responder.sv
// Memory-side read responder: queues tagged read commands, reads an internal write-first RAM,
// and returns data/tag in command order after RD_LAT cycles. The result pipeline is not backpressured.
module mem_rd_responder #(
   parameter int ADDR_W     = 10,
   parameter int MEM_ADDR_W = 16,
   parameter int DATA_W     = 512,
   parameter int TAG_W      = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int RD_LAT     = 2
) (
   input logic               eclk,
   input logic               rst,
   mem_rd_responder_if.slave mem_if_s
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [DATA_W-1:0] ram_q      [2**ADDR_W];
   logic [ADDR_W-1:0] fifo_addr_q[FIFO_DEPTH];
   logic [TAG_W-1:0]  fifo_tag_q [FIFO_DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              full_q, full_d;
   logic              ovf_q;
   logic [RD_LAT-1:0] vld_q;
   logic [TAG_W-1:0]  ptag_q [RD_LAT];
   logic [DATA_W-1:0] pdata_q[RD_LAT];

   logic              push, pop, drop;
   logic [ADDR_W-1:0] head_addr;
   logic [ADDR_W-1:0] wr_idx;
   logic [DATA_W-1:0] rd_word;

   generate
      if (MEM_ADDR_W > ADDR_W) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^{mem_if_s.raddr[MEM_ADDR_W-1:ADDR_W],
                                   mem_if_s.waddr[MEM_ADDR_W-1:ADDR_W]};
      end
   endgenerate

   always_comb begin
      pop       = (level_q != '0) && !mem_if_s.stall;
      // A full FIFO still takes a command when its head leaves on the same edge.
      push      = mem_if_s.rsend && ((level_q != LVL_W'(FIFO_DEPTH)) || pop);
      drop      = mem_if_s.rsend && !push;
      head_addr = fifo_addr_q[rd_ptr_q];
      wr_idx    = mem_if_s.waddr[ADDR_W-1:0];
      rd_word   = (mem_if_s.wvalid && (wr_idx == head_addr)) ? mem_if_s.wdata : ram_q[head_addr];
      level_d   = level_q;
      if (push && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
         level_d = level_q - LVL_W'(1);
      end
      full_d    = (level_d >= LVL_W'(FIFO_DEPTH - 2));
   end

   // Storage arrays carry no reset; only pointers and valid bits give them meaning.
   always_ff @(posedge eclk) begin
      if (mem_if_s.wvalid) begin
         ram_q[wr_idx] <= mem_if_s.wdata;
      end
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= mem_if_s.raddr[ADDR_W-1:0];
         fifo_tag_q[wr_ptr_q]  <= mem_if_s.rtag_in;
      end
   end

   always_ff @(posedge eclk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
         vld_q    <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            ptag_q[i]  <= '0;
            pdata_q[i] <= '0;
         end
      end else begin
         level_q <= level_d;
         full_q  <= full_d;
         if (drop) begin
            ovf_q <= 1'b1;
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         vld_q[0] <= pop;
         if (pop) begin
            ptag_q[0]  <= fifo_tag_q[rd_ptr_q];
            pdata_q[0] <= rd_word;
         end
         // Later stages only load behind a valid entry so rdata/rtag hold between responses.
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               ptag_q[i]  <= ptag_q[i-1];
               pdata_q[i] <= pdata_q[i-1];
            end
         end
      end
   end

   assign mem_if_s.rvalid        = vld_q[RD_LAT-1];
   assign mem_if_s.rdata         = pdata_q[RD_LAT-1];
   assign mem_if_s.rtag          = ptag_q[RD_LAT-1];
   assign mem_if_s.fifo_level    = level_q;
   assign mem_if_s.memc_cmd_full = full_q;
   assign mem_if_s.overflow      = ovf_q;
endmodule
